// File: rtl/pe_work_counter_pkg.sv
// Shared types and helpers for the PE work counter.
// State encoding, lane-width helper and saturating increment.
package pe_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int lane_w(input int lanes);
    return $clog2(lanes);
  endfunction

  // Holds at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] top;
    top = 32'hFFFF_FFFF >> (32 - w);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pe_work_counter_if.sv
// Control/status bundle between PE_control and its work counter.
// stall_cnt exists only when PE_CNT_STALL_EN is defined.
interface pe_work_counter_if #(
  parameter int LANES = 4,
  parameter int S_W   = 4,
  parameter int P_W   = 4,
  parameter int Q_W   = 4,
  parameter int TOT_W = 16
);
  import pe_cnt_pkg::*;
  localparam int LANE_W = lane_w(LANES);

  logic              start;
  logic              en;
  logic              abort;
  logic [S_W-1:0]    cfg_s;
  logic [P_W-1:0]    cfg_p;
  logic [Q_W-1:0]    cfg_q;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [LANE_W-1:0] lane_idx;
  logic [S_W-1:0]    s_idx;
  logic [P_W-1:0]    p_idx;
  logic [Q_W-1:0]    q_idx;
  logic [TOT_W-1:0]  total;
`ifdef PE_CNT_STALL_EN
  logic [TOT_W-1:0]  stall_cnt;
`endif

  modport master (
`ifdef PE_CNT_STALL_EN
    input  stall_cnt,
`endif
    output start, en, abort,
    output cfg_s, cfg_p, cfg_q,
    input  busy, done, cfg_err,
    input  lane_idx, s_idx, p_idx, q_idx,
    input  total
  );

  modport slave (
`ifdef PE_CNT_STALL_EN
    output stall_cnt,
`endif
    input  start, en, abort,
    input  cfg_s, cfg_p, cfg_q,
    output busy, done, cfg_err,
    output lane_idx, s_idx, p_idx, q_idx,
    output total
  );

endinterface

// File: rtl/pe_work_counter_wrap_cnt.sv
// One loop index: counts to limit, wraps to 0 and carries out.
// Falling-edge state to match PE_control.
module pe_wrap_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] idx,
  output logic         at_max,
  output logic         carry
);

  assign at_max = (idx == limit);
  assign carry  = inc & at_max;

  always_ff @(negedge clk) begin
    if (clr)
      idx <= '0;
    else if (inc)
      idx <= at_max ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/pe_work_counter.sv
// PE psum work counter: lane/S/P/Q indices, total, start/done handshake.
// Optional stall counter behind PE_CNT_STALL_EN.
module pe_work_counter
  import pe_cnt_pkg::*;
#(
  parameter int LANES = 4,
  parameter int S_W   = 4,
  parameter int P_W   = 4,
  parameter int Q_W   = 4,
  parameter int TOT_W = 16
) (
  input logic               clk,
  input logic               rst,
  pe_work_counter_if.slave  bus
);

  localparam int LANE_W = lane_w(LANES);
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);

  state_t           state;
  logic             busy, done, cfg_err;
  logic [S_W-1:0]   s_lim;
  logic [P_W-1:0]   p_lim;
  logic [Q_W-1:0]   q_lim;
  logic [TOT_W-1:0] total;

  logic cfg_ok, accept, reject, count;
  logic last, step, fin, clr;
  logic l_max, s_max, p_max, q_max;
  logic l_cy, s_cy, p_cy, q_cy;

  assign cfg_ok = (|bus.cfg_s) & (|bus.cfg_p) & (|bus.cfg_q);
  assign accept = (state == IDLE) & bus.start & cfg_ok;
  assign reject = (state == IDLE) & bus.start & ~cfg_ok;
  assign count  = (state == RUN) & bus.en & ~bus.abort;
  assign last   = l_max & s_max & p_max & q_max;
  // Final count keeps indices parked at their maxima.
  assign step   = count & ~last;
  assign fin    = (count & last) | q_cy;
  assign clr    = rst | accept;

  pe_wrap_cnt #(.W(LANE_W)) u_lane (
    .clk(clk), .clr(clr), .inc(step), .limit(LANE_MAX),
    .idx(bus.lane_idx), .at_max(l_max), .carry(l_cy)
  );

  pe_wrap_cnt #(.W(S_W)) u_s (
    .clk(clk), .clr(clr), .inc(l_cy), .limit(s_lim),
    .idx(bus.s_idx), .at_max(s_max), .carry(s_cy)
  );

  pe_wrap_cnt #(.W(P_W)) u_p (
    .clk(clk), .clr(clr), .inc(s_cy), .limit(p_lim),
    .idx(bus.p_idx), .at_max(p_max), .carry(p_cy)
  );

  pe_wrap_cnt #(.W(Q_W)) u_q (
    .clk(clk), .clr(clr), .inc(p_cy), .limit(q_lim),
    .idx(bus.q_idx), .at_max(q_max), .carry(q_cy)
  );

`ifdef PE_CNT_STALL_EN
  logic [TOT_W-1:0] stall_cnt;
  assign bus.stall_cnt = stall_cnt;

  always_ff @(negedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (accept)
      stall_cnt <= '0;
    else if (state == RUN && !bus.en && !bus.abort)
      stall_cnt <= TOT_W'(sat_inc(32'(stall_cnt), TOT_W));
  end
`endif

  always_ff @(negedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      total   <= '0;
      s_lim   <= '0;
      p_lim   <= '0;
      q_lim   <= '0;
    end else begin
      cfg_err <= reject;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            s_lim <= bus.cfg_s - 1'b1;
            p_lim <= bus.cfg_p - 1'b1;
            q_lim <= bus.cfg_q - 1'b1;
            total <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (bus.en) begin
            total <= TOT_W'(sat_inc(32'(total), TOT_W));
            if (fin) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.cfg_err = cfg_err;
  assign bus.total   = total;

endmodule

// File: tb/tb_pe_work_counter.sv
// Directed bench for pe_work_counter: default config plus a TOT_W=5 instance.
// Define PE_CNT_STALL_EN to also check stall_cnt.
module tb_pe_work_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pe_work_counter_if #(
    .LANES(4), .S_W(4), .P_W(4), .Q_W(4), .TOT_W(16)
  ) bus ();

  pe_work_counter_if #(
    .LANES(4), .S_W(4), .P_W(4), .Q_W(4), .TOT_W(5)
  ) bus2 ();

  pe_work_counter #(
    .LANES(4), .S_W(4), .P_W(4), .Q_W(4), .TOT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  pe_work_counter #(
    .LANES(4), .S_W(4), .P_W(4), .Q_W(4), .TOT_W(5)
  ) u_sat (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
  endtask

  // DUT updates on the falling edge; inputs change and outputs are
  // sampled just after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(
    input int s,
    input int p,
    input int q
  );
    bus.cfg_s = 4'(s);
    bus.cfg_p = 4'(p);
    bus.cfg_q = 4'(q);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts DUT edges until done; en low on every third edge if stall.
  task automatic run_done(
    input  bit stall,
    input  int hold_start,
    output int edges,
    output int stalls
  );
    edges  = 0;
    stalls = 0;
    while (edges < 400) begin
      bus.en    = !(stall && (edges % 3 == 2));
      bus.start = (edges < hold_start);
      if (!bus.en) stalls++;
      tick();
      edges++;
      if (bus.done) break;
    end
    bus.en    = 1'b1;
    bus.start = 1'b0;
    check("done_seen", bus.done, 1);
  endtask

  int e, st;

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.en = 0; bus.abort = 0;
    bus.cfg_s = 0; bus.cfg_p = 0; bus.cfg_q = 0;
    bus2.start = 0; bus2.en = 0; bus2.abort = 0;
    bus2.cfg_s = 0; bus2.cfg_p = 0; bus2.cfg_q = 0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_total", bus.total, 0);
    check("rst_lane", bus.lane_idx, 0);
    check("rst_q", bus.q_idx, 0);
`ifdef PE_CNT_STALL_EN
    check("rst_stall", bus.stall_cnt, 0);
`endif

    // Full run, en held high: 4*2*3*2 = 48 counted edges
    bus.en = 1'b1;
    start_run(2, 3, 2);
    check("a_busy", bus.busy, 1);
    check("a_total0", bus.total, 0);
    check("a_done0", bus.done, 0);
    run_done(0, 0, e, st);
    check("a_edges", e, 48);
    check("a_total", bus.total, 48);
    check("a_lane", bus.lane_idx, 3);
    check("a_s", bus.s_idx, 1);
    check("a_p", bus.p_idx, 2);
    check("a_q", bus.q_idx, 1);
    check("a_busy_done", bus.busy, 0);
    tick();
    check("a_done_pulse", bus.done, 0);
    check("a_total_hold", bus.total, 48);
    check("a_s_hold", bus.s_idx, 1);

    // en low on every third edge: 48 counts need 71 edges, 23 stalls
    start_run(2, 3, 2);
    run_done(1, 0, e, st);
    check("b_edges", e, 71);
    check("b_stalls", st, 23);
    check("b_total", bus.total, 48);
`ifdef PE_CNT_STALL_EN
    check("b_stall_cnt", bus.stall_cnt, 23);
`endif
    tick();

    // Rejected start: cfg_p = 0
    start_run(2, 0, 2);
    check("c_cfg_err", bus.cfg_err, 1);
    check("c_busy", bus.busy, 0);
    check("c_total", bus.total, 48);
    check("c_lane", bus.lane_idx, 3);
    tick();
    check("c_cfg_err_pulse", bus.cfg_err, 0);
    check("c_busy2", bus.busy, 0);

    // Abort at total=20 (lane 0, s 1, p 2, q 0)
    start_run(2, 3, 2);
    repeat (20) tick();
    check("d_total20", bus.total, 20);
    check("d_s20", bus.s_idx, 1);
    check("d_p20", bus.p_idx, 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("d_busy", bus.busy, 0);
    check("d_done", bus.done, 0);
    check("d_total_hold", bus.total, 20);
    tick();
    check("d_done2", bus.done, 0);
    check("d_total_hold2", bus.total, 20);
    start_run(2, 3, 2);
    check("d_restart_total", bus.total, 0);
    check("d_restart_busy", bus.busy, 1);
    run_done(0, 0, e, st);
    check("d_restart_edges", e, 48);
    tick();

    // Abort together with the final counting edge
    start_run(2, 3, 2);
    repeat (47) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("f_done", bus.done, 0);
    check("f_busy", bus.busy, 0);
    check("f_total", bus.total, 47);
    tick();
    check("f_done2", bus.done, 0);

    // Reset mid-run at total=10
    start_run(2, 3, 2);
    repeat (10) tick();
    check("e_total10", bus.total, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("e_busy", bus.busy, 0);
    check("e_total", bus.total, 0);
    check("e_lane", bus.lane_idx, 0);
    check("e_done", bus.done, 0);

    // start held and cfg_s changed during RUN have no effect
    start_run(2, 3, 2);
    bus.cfg_s = 4'd5;
    run_done(0, 5, e, st);
    check("e_edges", e, 48);
    check("e_total48", bus.total, 48);
    check("e_s_max", bus.s_idx, 1);
    bus.cfg_s = 4'd2;
    tick();
    check("e_idle", bus.busy, 0);

    // TOT_W=5 instance, 4*3*3*3 = 108 counted edges
    bus2.cfg_s = 4'd3;
    bus2.cfg_p = 4'd3;
    bus2.cfg_q = 4'd3;
    bus2.en    = 1'b1;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    e = 0;
    while (e < 400) begin
      tick();
      e++;
      if (bus2.done) break;
    end
    check("g_done_seen", bus2.done, 1);
    check("g_edges", e, 108);
    check("g_total_sat", bus2.total, 31);
    check("g_lane", bus2.lane_idx, 3);
    check("g_q", bus2.q_idx, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
